tb_pass_judge: RTL and testbench

Testbench-side verdict engine that consumes the statistics produced by the bench's tohost/cycle monitor (tohost write count, first-write cycle, fetched-instruction count, free-running cycle count) plus a core fail event, and decides PASS / FAIL / TIMEOUT with a settle window. It latches final run statistics for the end-of-sim report. With the optional CPI feature enabled, it runs a serial divider to produce cycles-per-instruction ×100. Sits directly downstream of the monitor in the bench top. Its outputs drive `$finish` and report logic.

---
 rtl/tb_pass_judge.sv | 195 +++++++++++++++++++
 tb/tb_tb_pass_judge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tb_pass_judge.sv
// tb_pass_judge: PASS/FAIL/TIMEOUT verdict engine downstream of the bench tohost/cycle monitor.
// Optional macro TB_PASS_JUDGE_CPI_EN adds a 40-cycle restoring divider for cycles-per-instruction x100.
module tb_pass_judge #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000,
    parameter logic [31:0] PASS_CNT       = 32'd1,
    parameter int unsigned SETTLE_CYCLES  = 8
) (
    input  logic        tb_clk,
    input  logic        tb_rst,
    input  logic [31:0] tohost_cnt,
    input  logic [31:0] tohost_cycle,
    input  logic [31:0] ir_cnt,
    input  logic [31:0] cycle_cnt,
    input  logic        fail_evt,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] final_cycles,
    output logic [31:0] final_instrs,
    output logic [31:0] cpi_x100,
    output logic        cpi_valid
);
    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

`ifdef TB_PASS_JUDGE_CPI_EN
    typedef enum logic [2:0] {IDLE, RUN, SETTLE, DIV, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RUN, SETTLE, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        done_q, done_d, pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
    logic [31:0] fc_q, fc_d, fi_q, fi_d;

`ifdef TB_PASS_JUDGE_CPI_EN
    // Numerator register doubles as the quotient register: freed low bits collect quotient bits.
    logic [39:0] num_q, num_d;
    logic [31:0] rem_q, rem_d, cpi_q, cpi_d;
    logic [5:0]  div_cnt_q, div_cnt_d;
    logic        cpi_vld_q, cpi_vld_d;
    logic [32:0] trial;

    function automatic logic [31:0] sat_q32(input logic [39:0] q);
        return (|q[39:32]) ? 32'hFFFF_FFFF : q[31:0];
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        fc_d    = fc_q;
        fi_d    = fi_q;
`ifdef TB_PASS_JUDGE_CPI_EN
        num_d     = num_q;
        rem_d     = rem_q;
        cpi_d     = cpi_q;
        div_cnt_d = div_cnt_q;
        cpi_vld_d = cpi_vld_q;
        trial     = '0;
`endif
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN, SETTLE: begin
                if (fail_evt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    fc_d    = cycle_cnt;
                    fi_d    = ir_cnt;
                end else if (cycle_cnt >= TIMEOUT_CYCLES) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    tmo_d   = 1'b1;
                    fc_d    = cycle_cnt;
                    fi_d    = ir_cnt;
                end else if (state_q == RUN) begin
                    if (tohost_cnt >= PASS_CNT) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_RELOAD;
                        snap_d  = tohost_cnt;
                    end
                end else if (tohost_cnt != snap_q) begin
                    cnt_d  = SETTLE_RELOAD;
                    snap_d = tohost_cnt;
                end else if (cnt_q == 8'd0) begin
                    fc_d = tohost_cycle;
                    fi_d = ir_cnt;
`ifdef TB_PASS_JUDGE_CPI_EN
                    state_d   = DIV;
                    num_d     = {8'd0, tohost_cycle} * 40'd100;
                    rem_d     = '0;
                    div_cnt_d = 6'd39;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`ifdef TB_PASS_JUDGE_CPI_EN
            DIV: begin
                if (fi_q == '0) begin
                    cpi_d     = 32'hFFFF_FFFF;
                    state_d   = DONE;
                    done_d    = 1'b1;
                    pass_d    = 1'b1;
                    cpi_vld_d = 1'b1;
                end else begin
                    trial = {rem_q, num_q[39]};
                    if (trial >= {1'b0, fi_q}) begin
                        rem_d = trial[31:0] - fi_q;
                        num_d = {num_q[38:0], 1'b1};
                    end else begin
                        rem_d = trial[31:0];
                        num_d = {num_q[38:0], 1'b0};
                    end
                    div_cnt_d = div_cnt_q - 6'd1;
                    if (div_cnt_q == 6'd0) begin
                        cpi_d     = sat_q32(num_d);
                        state_d   = DONE;
                        done_d    = 1'b1;
                        pass_d    = 1'b1;
                        cpi_vld_d = 1'b1;
                    end
                end
            end
`endif
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tb_clk) begin
        if (tb_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
            fc_q    <= '0;
            fi_q    <= '0;
`ifdef TB_PASS_JUDGE_CPI_EN
            num_q     <= '0;
            rem_q     <= '0;
            cpi_q     <= '0;
            div_cnt_q <= '0;
            cpi_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            fc_q    <= fc_d;
            fi_q    <= fi_d;
`ifdef TB_PASS_JUDGE_CPI_EN
            num_q     <= num_d;
            rem_q     <= rem_d;
            cpi_q     <= cpi_d;
            div_cnt_q <= div_cnt_d;
            cpi_vld_q <= cpi_vld_d;
`endif
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = tmo_q;
    assign final_cycles = fc_q;
    assign final_instrs = fi_q;
`ifdef TB_PASS_JUDGE_CPI_EN
    assign cpi_x100  = cpi_q;
    assign cpi_valid = cpi_vld_q;
`else
    assign cpi_x100  = 32'd0;
    assign cpi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_tb_pass_judge.sv
// Bench for tb_pass_judge: directed scenarios plus randomized runs, checked every cycle against
// a verdict model built from consecutive-unchanged-sample counting.
module tb_tb_pass_judge;
    localparam logic [31:0] TO    = 32'd500;
    localparam logic [31:0] PC    = 32'd1;
    localparam int          SC    = 8;
    localparam int          NEVER = 1_000_000;
`ifdef TB_PASS_JUDGE_CPI_EN
    localparam int DIV_EDGES = 40;
`else
    localparam int DIV_EDGES = 0;
`endif

    logic        tb_clk = 1'b0;
    logic        tb_rst = 1'b1;
    logic [31:0] tohost_cnt = '0, tohost_cycle = '0, ir_cnt = '0, cycle_cnt = '0;
    logic        fail_evt = 1'b0;
    logic        done, pass, fail, timeout, cpi_valid;
    logic [31:0] final_cycles, final_instrs, cpi_x100;

    always #5 tb_clk = ~tb_clk;

    tb_pass_judge #(.TIMEOUT_CYCLES(TO), .PASS_CNT(PC), .SETTLE_CYCLES(SC)) dut (
        .tb_clk(tb_clk), .tb_rst(tb_rst), .tohost_cnt(tohost_cnt), .tohost_cycle(tohost_cycle),
        .ir_cnt(ir_cnt), .cycle_cnt(cycle_cnt), .fail_evt(fail_evt), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .final_cycles(final_cycles), .final_instrs(final_instrs),
        .cpi_x100(cpi_x100), .cpi_valid(cpi_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

`ifdef TB_PASS_JUDGE_CPI_EN
    function automatic logic [31:0] cpi_of(input logic [31:0] cyc, input logic [31:0] ins);
        longint unsigned q;
        if (ins == 0) return 32'hFFFF_FFFF;
        q = ({32'd0, cyc} * 64'd100) / {32'd0, ins};
        return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction
`endif

    // Reference model: verdict from the rule "tohost count armed, then SC consecutive unchanged samples"
    bit          chk_en = 1'b0;
    bit          m_started, m_armed, m_decided;
    int          m_stable, m_div_left, last_samp_c;
    logic        m_done, m_pass, m_fail, m_tmo, m_cpi_vld;
    logic [31:0] m_snap, m_fc, m_fi, m_cpi, m_cpi_pend;

    initial forever begin
        @(posedge tb_clk);
        last_samp_c = int'(cycle_cnt);
        if (tb_rst) begin
            chk_en = 1'b1;
            m_started = 0; m_armed = 0; m_decided = 0; m_stable = 0; m_div_left = 0;
            m_done = 0; m_pass = 0; m_fail = 0; m_tmo = 0; m_cpi_vld = 0;
            m_snap = '0; m_fc = '0; m_fi = '0; m_cpi = '0; m_cpi_pend = '0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_div_left > 0) begin
            m_div_left--;
            if (m_div_left == 0) begin
                m_done = 1; m_pass = 1; m_cpi = m_cpi_pend; m_cpi_vld = 1;
            end
        end else if (!m_decided) begin
            if (fail_evt) begin
                m_decided = 1; m_done = 1; m_fail = 1; m_fc = cycle_cnt; m_fi = ir_cnt;
            end else if (cycle_cnt >= TO) begin
                m_decided = 1; m_done = 1; m_tmo = 1; m_fc = cycle_cnt; m_fi = ir_cnt;
            end else if (!m_armed) begin
                if (tohost_cnt >= PC) begin
                    m_armed = 1; m_snap = tohost_cnt; m_stable = 0;
                end
            end else if (tohost_cnt != m_snap) begin
                m_snap = tohost_cnt; m_stable = 0;
            end else begin
                m_stable++;
                if (m_stable == SC) begin
                    m_decided = 1; m_fc = tohost_cycle; m_fi = ir_cnt;
`ifdef TB_PASS_JUDGE_CPI_EN
                    m_cpi_pend = cpi_of(tohost_cycle, ir_cnt);
                    m_div_left = (ir_cnt == 0) ? 1 : 40;
`else
                    m_done = 1; m_pass = 1;
`endif
                end
            end
        end
    end

    int first_done = -1;

    initial forever begin
        @(negedge tb_clk);
        if (chk_en) begin
            chk1("done", done, m_done);
            chk1("pass", pass, m_pass);
            chk1("fail", fail, m_fail);
            chk1("timeout", timeout, m_tmo);
            chk32("final_cycles", final_cycles, m_fc);
            chk32("final_instrs", final_instrs, m_fi);
            chk32("cpi_x100", cpi_x100, m_cpi);
            chk1("cpi_valid", cpi_valid, m_cpi_vld);
        end
        if (done === 1'b1 && first_done < 0) first_done = last_samp_c;
    end

    // One run: reset for a cycle, then drive n cycles with cycle_cnt = c, tohost stepping at t1/t2
    task automatic scenario(input int n, input int t1, input int t2, input int f_at,
                            input logic [31:0] tcyc, input logic [31:0] irc);
        @(negedge tb_clk);
        tb_rst = 1'b1; fail_evt = 1'b0; tohost_cnt = '0; cycle_cnt = '0;
        @(negedge tb_clk);
        chk1("rst_done", done, 1'b0);
        chk1("rst_pass", pass, 1'b0);
        chk1("rst_fail", fail, 1'b0);
        chk32("rst_final_cycles", final_cycles, 32'd0);
        first_done = -1;
        tb_rst = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge tb_clk);
            cycle_cnt    = 32'(c);
            tohost_cnt   = (c >= t2) ? 32'd2 : (c >= t1) ? 32'd1 : 32'd0;
            fail_evt     = (c == f_at);
            tohost_cycle = tcyc;
            ir_cnt       = irc;
        end
        @(negedge tb_clk);
        fail_evt = 1'b0;
    endtask

    task automatic check_pass_run(input string tag, input int exp_edge, input logic [31:0] fc,
                                  input logic [31:0] fi, input logic [31:0] cpi);
        chk32({tag, "_edge"}, 32'(first_done), 32'(exp_edge));
        chk1({tag, "_pass"}, pass, 1'b1);
        chk1({tag, "_fail"}, fail, 1'b0);
        chk32({tag, "_fc"}, final_cycles, fc);
        chk32({tag, "_fi"}, final_instrs, fi);
`ifdef TB_PASS_JUDGE_CPI_EN
        chk32({tag, "_cpi"}, cpi_x100, cpi);
        chk1({tag, "_cpi_valid"}, cpi_valid, 1'b1);
`else
        chk32({tag, "_cpi"}, cpi_x100, 32'd0 & cpi);
        chk1({tag, "_cpi_valid"}, cpi_valid, 1'b0);
`endif
    endtask

    initial begin
        // Pass path with defaults
        scenario(130 + DIV_EDGES, 100, NEVER, NEVER, 32'd100, 32'd50);
        check_pass_run("pass_path", 108 + DIV_EDGES, 32'd100, 32'd50, 32'd200);
        chk32("model_fc", m_fc, 32'd100);

        // Fail pulse at cycle 30, then hold for 1000 cycles (cycle_cnt crosses TO meanwhile)
        scenario(1031, NEVER, NEVER, 30, 32'd7, 32'd9);
        chk32("fail_edge", 32'(first_done), 32'd30);
        chk1("fail_fail", fail, 1'b1);
        chk1("fail_pass", pass, 1'b0);
        chk1("fail_timeout", timeout, 1'b0);
        chk32("fail_fc", final_cycles, 32'd30);
        chk32("fail_fi", final_instrs, 32'd9);
        chk1("model_fail", m_fail, 1'b1);

        // Settle restart on a second tohost write
        scenario(60 + DIV_EDGES, 10, 14, NEVER, 32'd11, 32'd5);
        check_pass_run("restart", 22 + DIV_EDGES, 32'd11, 32'd5, 32'd220);

        // Fail on the same cycle the settle window expires
        scenario(40, 10, NEVER, 18, 32'd3, 32'd4);
        chk32("collide_edge", 32'(first_done), 32'd18);
        chk1("collide_fail", fail, 1'b1);
        chk1("collide_pass", pass, 1'b0);
        chk32("collide_fc", final_cycles, 32'd18);

        // Timeout with tohost never written
        scenario(520, NEVER, NEVER, NEVER, 32'd0, 32'd0);
        chk32("tmo_edge", 32'(first_done), 32'd500);
        chk1("tmo_timeout", timeout, 1'b1);
        chk1("tmo_pass", pass, 1'b0);
        chk32("tmo_fc", final_cycles, 32'd500);
        chk1("model_tmo", m_tmo, 1'b1);

        // Abandon mid-settle (or mid-divide), then rerun the pass path
        scenario(DIV_EDGES > 0 ? 120 : 105, 100, NEVER, NEVER, 32'd100, 32'd50);
        chk1("abandon_done", done, 1'b0);
        scenario(130 + DIV_EDGES, 100, NEVER, NEVER, 32'd100, 32'd50);
        check_pass_run("rerun", 108 + DIV_EDGES, 32'd100, 32'd50, 32'd200);

        // Randomized runs checked by the model every cycle
        for (int i = 0; i < 14; i++) begin
            int t1, t2, f_at;
            logic [31:0] tcyc, irc;
            t1   = int'($urandom_range(520, 3));
            t2   = ($urandom % 2 == 0) ? t1 + int'($urandom_range(12, 1)) : NEVER;
            f_at = ($urandom % 3 == 0) ? int'($urandom_range(560, 1)) : NEVER;
            tcyc = $urandom;
            irc  = ($urandom % 4 == 0) ? 32'd0 : 32'($urandom_range(100000, 1));
            scenario(620, t1, t2, f_at, tcyc, irc);
            chk1("rand_done", done, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
